// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline latch control: stalls, jump flush, interrupt drain
// Optional counters enabled by PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int NSTAGES = 5,
  parameter int JSTAGE  = 1,
  parameter int CNTW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NSTAGES-1:0]         busy,
  input  logic                       hazard,
  input  logic                       jmp,
  input  logic                       intr,
  output logic [2*(NSTAGES-1)-1:0]   ctr,
  output logic [NSTAGES-1:0]         valid,
  output logic                       fe_en,
  output logic                       jmp_take,
  output logic                       int_ack,
  output logic [CNTW-1:0]            stall_cnt,
  output logic [CNTW-1:0]            flush_cnt
);

  localparam int NL = NSTAGES - 1;
  localparam logic [1:0] C_LOAD  = 2'b00;
  localparam logic [1:0] C_HOLD  = 2'b01;
  localparam logic [1:0] C_FLUSH = 2'b10;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ACK} state_e;

  state_e               state_q, state_d;
  logic [NSTAGES-1:1]   valid_q, valid_d;
  logic [NSTAGES-1:0]   eb;
  logic                 v0;
  logic                 fetch_run;
  int                   stall_s;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (intr) state_d = ST_DRAIN;
      ST_DRAIN: if (valid_q == '0) state_d = ST_ACK;
      ST_ACK:   state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // fetch stops in the very cycle intr is seen, before the state register moves
  always_comb begin
    v0        = 1'b0;
    fetch_run = 1'b0;
    int_ack   = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          v0        = 1'b1;
          fetch_run = ~intr;
        end
        ST_ACK:  int_ack = 1'b1;
        default: ;
      endcase
    end
  end

  assign valid = rst ? '0 : {valid_q, v0};

  always_comb begin
    eb    = busy & valid;
    eb[1] = eb[1] | (hazard & valid[1]);
  end

  always_comb begin
    stall_s = -1;
    for (int i = 0; i < NSTAGES; i++) begin
      if (eb[i]) stall_s = i;
    end
  end

  assign jmp_take = ~rst & jmp & valid[JSTAGE] & ~(|eb[NSTAGES-1:JSTAGE]);

  always_comb begin
    ctr = '0;
    for (int k = 0; k < NL; k++) begin
      ctr[2*k +: 2] = C_LOAD;
      if (stall_s >= 0) begin
        if (stall_s == NSTAGES-1 || k < stall_s) ctr[2*k +: 2] = C_HOLD;
        else if (k == stall_s)                   ctr[2*k +: 2] = C_FLUSH;
      end
      if (jmp_take && k < JSTAGE) ctr[2*k +: 2] = C_FLUSH;
      if (k == 0 && !fetch_run && ctr[1:0] != C_HOLD) ctr[1:0] = C_FLUSH;
      if (rst) ctr[2*k +: 2] = C_FLUSH;
    end
  end

  assign fe_en = ~rst & (jmp_take | (fetch_run & (ctr[1:0] != C_HOLD)));

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < NL; k++) begin
      case (ctr[2*k +: 2])
        C_LOAD:  valid_d[k+1] = valid[k];
        C_FLUSH: valid_d[k+1] = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  logic            any_hold;
  logic [CNTW-1:0] stall_cnt_q, flush_cnt_q;

  always_comb begin
    any_hold = 1'b0;
    for (int k = 0; k < NL; k++) begin
      if (ctr[2*k +: 2] == C_HOLD) any_hold = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (any_hold && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (jmp_take && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks of pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam int N = 5;
  localparam int J = 1;
  localparam int W = 16;
  localparam int LD = 0, HD = 1, FL = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     busy;
  logic             hazard, jmp, intr;
  logic [2*N-3:0]   ctr;
  logic [N-1:0]     valid;
  logic             fe_en, jmp_take, int_ack;
  logic [W-1:0]     stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  pipe_hazard_ctrl #(.NSTAGES(N), .JSTAGE(J), .CNTW(W)) dut (
    .clk(clk), .rst(rst), .busy(busy), .hazard(hazard), .jmp(jmp), .intr(intr),
    .ctr(ctr), .valid(valid), .fe_en(fe_en), .jmp_take(jmp_take), .int_ack(int_ack),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  // reference model: stage occupancy array plus a mode number (0 run, 1 drain, 2 ack)
  int mv [N];
  int mmode = 0;
  int mstall = 0, mflush = 0;

  always @(negedge clk) begin
    int ev [N];
    int act [N-1];
    int s, fetching, jt, fe, any_hold, emptied;
    logic [2*N-3:0] ectr;
    logic [N-1:0]   evalid;
    if (chk_on) begin
      for (int i = 0; i < N; i++) ev[i] = rst ? 0 : ((i == 0) ? (mmode == 0) : mv[i]);
      s = -1;
      for (int i = N-1; i >= 0 && s < 0; i--)
        if ((busy[i] && ev[i] != 0) || (i == 1 && hazard && ev[1] != 0)) s = i;
      jt = (!rst && jmp && ev[J] != 0 && s < J) ? 1 : 0;
      fetching = (!rst && mmode == 0 && !intr) ? 1 : 0;
      for (int k = 0; k < N-1; k++) begin
        if (rst)                   act[k] = FL;
        else if (jt != 0 && k < J) act[k] = FL;
        else if (s == N-1)         act[k] = HD;
        else if (k < s)            act[k] = HD;
        else if (k == s)           act[k] = FL;
        else                       act[k] = LD;
      end
      if (fetching == 0 && act[0] != HD) act[0] = FL;
      fe = (!rst && (jt != 0 || (fetching != 0 && act[0] != HD))) ? 1 : 0;
      any_hold = 0;
      for (int k = 0; k < N-1; k++) begin
        ectr[2*k +: 2] = 2'(act[k]);
        if (act[k] == HD) any_hold = 1;
      end
      for (int i = 0; i < N; i++) evalid[i] = (ev[i] != 0);

      chk("ctr", 32'(ctr), 32'(ectr));
      chk("valid", 32'(valid), 32'(evalid));
      chk("fe_en", 32'(fe_en), 32'(fe));
      chk("jmp_take", 32'(jmp_take), 32'(jt));
      chk("int_ack", 32'(int_ack), 32'((!rst && mmode == 2) ? 1 : 0));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(mstall));
      chk("flush_cnt", 32'(flush_cnt), 32'(mflush));
`else
      chk("stall_cnt", 32'(stall_cnt), 32'd0);
      chk("flush_cnt", 32'(flush_cnt), 32'd0);
`endif

      if (rst) begin
        for (int i = 0; i < N; i++) mv[i] = 0;
        mmode = 0; mstall = 0; mflush = 0;
      end else begin
        emptied = 1;
        for (int i = 1; i < N; i++) if (ev[i] != 0) emptied = 0;
        for (int k = N-2; k >= 0; k--) begin
          if (act[k] == LD)      mv[k+1] = ev[k];
          else if (act[k] == FL) mv[k+1] = 0;
        end
        if (mmode == 0)      mmode = intr ? 1 : 0;
        else if (mmode == 1) mmode = emptied ? 2 : 1;
        else                 mmode = 0;
        if (any_hold != 0 && mstall < (1 << W) - 1) mstall++;
        if (jt != 0 && mflush < (1 << W) - 1) mflush++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    busy = '0; hazard = 1'b0; jmp = 1'b0; intr = 1'b0;
  endtask

  task automatic see();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    chk_on = 1'b1;
    #1;
    step(); step();
    see();
    chk("rst_ctr", 32'(ctr), 32'h0000_00aa);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_fe_en", 32'(fe_en), 32'h0);

    step(); rst = 1'b0;
    see();
    chk("post_rst_valid", 32'(valid), 32'h01);
    chk("post_rst_ctr", 32'(ctr), 32'h00);
    chk("post_rst_fe_en", 32'(fe_en), 32'h1);
    repeat (4) step();
    see();
    chk("fill_valid", 32'(valid), 32'h1f);

    for (int c = 0; c < 3; c++) begin
      step(); busy = 5'b01000;
      see();
      chk("busy3_ctr", 32'(ctr), 32'h95);
      chk("busy3_fe_en", 32'(fe_en), 32'h0);
    end
    step(); idle();
    see();
    chk("busy3_valid_after", 32'(valid), 32'h0f);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk("busy3_stall_cnt", 32'(stall_cnt), 32'd3);
`else
    chk("busy3_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    step(); hazard = 1'b1;
    see();
    chk("hazard_ctr", 32'(ctr), 32'h09);
    chk("hazard_fe_en", 32'(fe_en), 32'h0);
    step(); idle();
    see();
    chk("hazard_valid_after", 32'(valid), 32'h1b);

    for (int c = 0; c < 2; c++) begin
      step(); jmp = 1'b1; busy = 5'b00100;
      see();
      chk("jmp_blocked", 32'(jmp_take), 32'h0);
      chk("jmp_blocked_ctr", 32'(ctr), 32'h25);
    end
    step(); busy = '0;
    see();
    chk("jmp_taken", 32'(jmp_take), 32'h1);
    chk("jmp_ctr", 32'(ctr), 32'h02);
    chk("jmp_fe_en", 32'(fe_en), 32'h1);
    step(); idle();
    see();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk("jmp_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("jmp_stall_cnt", 32'(stall_cnt), 32'd6);
`else
    chk("jmp_flush_cnt", 32'(flush_cnt), 32'd0);
`endif

    repeat (3) step();
    step(); intr = 1'b1;
    see();
    chk("intr_fe_en", 32'(fe_en), 32'h0);
    chk("intr_ctr0", 32'(ctr[1:0]), 32'h2);
    for (int c = 1; c <= 5; c++) begin
      step(); intr = 1'b0;
      see();
      chk("intr_ack", 32'(int_ack), (c == 5) ? 32'h1 : 32'h0);
    end
    step();
    see();
    chk("intr_resume_fe_en", 32'(fe_en), 32'h1);
    chk("intr_resume_valid", 32'(valid), 32'h01);

    repeat (4) step();
    step(); intr = 1'b1;
    step(); intr = 1'b0;
    step();
    step(); rst = 1'b1;
    see();
    chk("drain_rst_ctr", 32'(ctr), 32'h0000_00aa);
    chk("drain_rst_ack", 32'(int_ack), 32'h0);
    step(); rst = 1'b0;
    see();
    chk("drain_rst_valid", 32'(valid), 32'h01);
    for (int c = 0; c < 8; c++) begin
      step();
      see();
      chk("drain_rst_no_ack", 32'(int_ack), 32'h0);
    end

    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N; i++) busy[i] = ($urandom_range(7) == 0);
      hazard = ($urandom_range(7) == 0);
      jmp    = ($urandom_range(3) == 0);
      intr   = ($urandom_range(31) == 0);
      rst    = ($urandom_range(199) == 0);
    end
    step(); idle(); rst = 1'b0;
    see();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NSTAGES, default 5, number of pipeline stages (min 3); latch k sits between stage k and k+1, k=0..NSTAGES-2.
REQ-002 SHALL have parameter JSTAGE, default 1, stage index that resolves jumps (1..NSTAGES-2).
REQ-003 SHALL have parameter CNTW, default 16, width of performance counters.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 busy  input  NSTAGES  per-stage multi-cycle busy; bit i = stage i cannot complete this cycle.
REQ-007 hazard  input  1  load-use hazard detected in stage 1.
REQ-008 jmp  input  1  redirect resolved in stage JSTAGE; source holds it until taken.
REQ-009 intr  input  1  interrupt request, level.
REQ-010 ctr  output  2*(NSTAGES-1)  per-latch control, field k = bits [2k+1:2k]; 00 LOAD, 01 HOLD, 10 FLUSH (load bubble), 11 never driven.
REQ-011 valid  output  NSTAGES  per-stage valid-instruction flags.
REQ-012 fe_en  output  1  fetch may advance PC this cycle.
REQ-013 jmp_take  output  1  redirect accepted this cycle; fetch loads target.
REQ-014 int_ack  output  1  one-cycle pulse: pipeline drained, interrupt accepted.
REQ-015 stall_cnt, flush_cnt  output  CNTW each  performance counters (see Configuration).

Function
REQ-016 Effective busy: eb[i] = busy[i] & valid[i]; eb[1] additionally ORed with hazard & valid[1].
REQ-017 s = highest i with eb[i]=1; if none, no stall.
REQ-018 Stall: latches k<s HOLD; latch s FLUSH when s<NSTAGES-1; latches k>s LOAD; s=NSTAGES-1 holds all latches.
REQ-019 Jump taken (jmp_take=1) only when jmp & valid[JSTAGE] & no eb[i] for i>=JSTAGE; then latches k<JSTAGE FLUSH, others per REQ-018/LOAD.
REQ-020 Stall at stage >=JSTAGE SHALL win over jump; jmp stays pending, no latch flushed by jump that cycle.
REQ-021 Stall at stage <JSTAGE with jump taken: jump flush overrides HOLD for latches k<JSTAGE.
REQ-022 Valid update per latch: LOAD copies valid[k] to valid[k+1]; HOLD keeps valid[k+1]; FLUSH clears valid[k+1]; valid[0] = 1 in RUN, 0 otherwise.
REQ-023 fe_en = state RUN & latch 0 not HOLD; fe_en=1 in the jmp_take cycle.
REQ-024 FSM states RUN, DRAIN, ACK; RUN->DRAIN when intr=1 (sampled same cycle fetch stops); DRAIN->ACK when valid[NSTAGES-1:1]==0; ACK->RUN unconditionally.
REQ-025 In DRAIN: latch 0 FLUSH each cycle (unless held by stall), fe_en=0, jumps still taken; in ACK: int_ack=1 for exactly one cycle.
REQ-026 intr in DRAIN/ACK ignored; intr still high in RUN after ACK re-enters DRAIN next cycle.
REQ-027 All outputs except counters combinational from state + inputs; no extra latency beyond one register per valid bit.

Reset
REQ-028 While rst=1: all ctr fields FLUSH, fe_en=0, jmp_take=0, int_ack=0, valid=0, state RUN, counters 0.
REQ-029 Reset mid-drain or mid-stall SHALL abandon operation; first cycle after rst deassertion: valid[0]=1, all latches LOAD.

Configuration
REQ-030 Macro PIPE_HAZARD_CTRL_PERF_EN defined: stall_cnt increments each cycle any latch is HOLD, flush_cnt each cycle jmp_take=1; both saturate at all-ones, clear on rst.
REQ-031 Macro undefined: stall_cnt and flush_cnt ports present, tied to 0, no counter flops.

Verification
REQ-032 NSTAGES=5, busy[3]=1 for 3 cycles, stages valid -> ctr latches0-2 HOLD, latch3 FLUSH each cycle; valid[4]=0 after; stall_cnt=3.
REQ-033 hazard=1 one cycle, no busy -> latch0 HOLD, latch1 FLUSH, latches2-3 LOAD; fe_en=0 that cycle.
REQ-034 jmp=1 with busy[2]=1 for 2 cycles -> jmp_take=0 both cycles, =1 on third; latch0 FLUSH that cycle; flush_cnt=1.
REQ-035 intr=1 one cycle in steady RUN -> fe_en=0 from that cycle; int_ack pulses once when valid[4:1]==0 (5th cycle after intr); fe_en=1 following cycle.
REQ-036 rst asserted during DRAIN -> next cycle all FLUSH, int_ack never pulses; after release valid=5'b00001.
REQ-037 Without PIPE_HAZARD_CTRL_PERF_EN rerun REQ-032 -> stall_cnt=0, flush_cnt=0, all ctr behaviour identical.
